// File: rtl/fpu_mul.sv
// fpu_mul: IEEE-754 binary32 multiplier, round-to-nearest-ties-to-even.
// Full subnormal support (inputs and gradual-underflow outputs).
// Every NaN result is emitted as the canonical quiet NaN 32'h7FC00000.
//
// Ports:
//   i_clk    - clock (used only with FPU_MUL_OUT_REG_EN)
//   i_rst_n  - asynchronous active-low reset (used only with FPU_MUL_OUT_REG_EN)
//   i_32_a   - binary32 multiplicand
//   i_32_b   - binary32 multiplier
//   o_32_mul - binary32 product a*b
//
// Configuration macro FPU_MUL_OUT_REG_EN:
//   defined   : o_32_mul is registered on i_clk (1-cycle latency, cleared by reset)
//   undefined : o_32_mul is purely combinational (latency 0)
module fpu_mul #(
  parameter int unsigned SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_DATA-1:0] i_32_a,
  input  logic [SIZE_DATA-1:0] i_32_b,
  output logic [SIZE_DATA-1:0] o_32_mul
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned IEXP_W = 12;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  // Leading-zero count of the 48-bit significand product.
  // The scan runs upward so the highest set bit wins.
  function automatic logic [5:0] lzc48(input logic [PROD_W-1:0] v);
    logic [5:0] n;
    n = 6'd48;
    for (int i = 0; i < int'(PROD_W); i++) begin
      if (v[i]) n = 6'(47 - i);
    end
    return n;
  endfunction

  // Operand fields
  logic              sign_a, sign_b, sign_r;
  logic [EXP_W-1:0]  exp_a, exp_b, exp_a_eff, exp_b_eff;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [SIG_W-1:0]  sig_a, sig_b;

  // Classification
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Datapath
  logic [PROD_W-1:0]        prod;
  logic [5:0]               lz;
  logic [PROD_W-1:0]        norm;
  logic [IEXP_W-1:0]        exp_u;
  logic signed [IEXP_W-1:0] exp_s;
  logic [4:0]               shamt;
  logic [PROD_W-1:0]        work;
  logic                     lost;
  logic [EXP_W-1:0]         exp_field;
  logic                     guard_b, round_b, sticky_b, lsb_b, rnd_up;
  logic [EXP_W+FRAC_W-1:0]  mag;
  logic                     ovf;
  logic [31:0]              mul_c;
  logic                     unused_c;

  // Unpack and classify both operands
  always_comb begin
    sign_a    = i_32_a[31];
    sign_b    = i_32_b[31];
    exp_a     = i_32_a[30:23];
    exp_b     = i_32_b[30:23];
    frac_a    = i_32_a[22:0];
    frac_b    = i_32_b[22:0];
    sign_r    = sign_a ^ sign_b;

    a_nan     = (exp_a == 8'hFF) && (frac_a != '0);
    b_nan     = (exp_b == 8'hFF) && (frac_b != '0);
    a_inf     = (exp_a == 8'hFF) && (frac_a == '0);
    b_inf     = (exp_b == 8'hFF) && (frac_b == '0);
    a_zero    = (exp_a == '0) && (frac_a == '0);
    b_zero    = (exp_b == '0) && (frac_b == '0);

    // Subnormals: hidden bit 0, exponent field treated as 1
    exp_a_eff = (exp_a == '0) ? 8'd1 : exp_a;
    exp_b_eff = (exp_b == '0) ? 8'd1 : exp_b;
    sig_a     = {(exp_a != '0), frac_a};
    sig_b     = {(exp_b != '0), frac_b};
  end

  // Multiply, normalise, align for underflow, round and pack
  always_comb begin
    prod      = PROD_W'(sig_a) * PROD_W'(sig_b);
    lz        = lzc48(prod);
    norm      = prod << lz;

    // norm = 1.f * 2^-47 scaled, so biased exponent is ea+eb-127+1-lz
    exp_u     = IEXP_W'(exp_a_eff) + IEXP_W'(exp_b_eff) - IEXP_W'(126) - IEXP_W'(lz);
    exp_s     = $signed(exp_u);

    shamt     = '0;
    work      = norm;
    lost      = 1'b0;
    exp_field = exp_u[EXP_W-1:0];

    if (exp_s < 12'sd1) begin
      exp_field = '0;
      if (exp_s <= -12'sd25) begin
        // Shift of 26 or more: everything lands below the round position
        work = '0;
        lost = 1'b1;
      end else begin
        shamt = 5'(IEXP_W'(1) - exp_u);
        work  = norm >> shamt;
        lost  = |(norm & ((PROD_W'(1) << shamt) - PROD_W'(1)));
      end
    end

    guard_b   = work[23];
    round_b   = work[22];
    sticky_b  = (|work[21:0]) | lost;
    lsb_b     = work[24];
    rnd_up    = guard_b & (round_b | sticky_b | lsb_b);

    // Adding on the packed {exp,frac} lets a rounding carry bump the exponent,
    // which also turns the largest subnormal into the minimum normal.
    mag       = {exp_field, work[46:24]} + (EXP_W + FRAC_W)'(rnd_up);
    ovf       = (exp_s >= 12'sd255) || (mag[30:23] == 8'hFF);

    mul_c     = {sign_r, mag};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      mul_c = QNAN;
    end else if (a_inf || b_inf || ovf) begin
      mul_c = {sign_r, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      mul_c = {sign_r, 31'd0};
    end
  end

`ifdef FPU_MUL_OUT_REG_EN
  logic [SIZE_DATA-1:0] mul_q;

  // Output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mul_q <= '0;
    end else begin
      mul_q <= SIZE_DATA'(mul_c);
    end
  end

  assign o_32_mul = mul_q;
  // work[47] is the hidden bit, implied by the exponent field
  assign unused_c = work[47];
`else
  assign o_32_mul = SIZE_DATA'(mul_c);
  // Clock and reset are kept on the port list for drop-in compatibility
  assign unused_c = ^{work[47], i_clk, i_rst_n};
`endif

endmodule

// File: tb/tb_fpu_mul.sv
// Directed self-checking bench for fpu_mul; works with or without FPU_MUL_OUT_REG_EN.
module tb_fpu_mul;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_32_a;
  logic [31:0] i_32_b;
  logic [31:0] o_32_mul;

  int tests_run;
  int tests_failed;

  fpu_mul #(.SIZE_DATA(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_32_a   (i_32_a),
    .i_32_b   (i_32_b),
    .o_32_mul (o_32_mul)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands, wait one edge, sample 1 time unit later
  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    i_32_a = a;
    i_32_b = b;
    @(posedge i_clk);
    #1;
    check(tag, o_32_mul, exp);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_rst_n      = 1'b0;
    i_32_a       = 32'h3F80_0000;
    i_32_b       = 32'h4000_0000;
    #2;
`ifdef FPU_MUL_OUT_REG_EN
    check("reset_out", o_32_mul, 32'h0000_0000);
    @(posedge i_clk);
    #1;
    check("reset_hold_edge", o_32_mul, 32'h0000_0000);
`else
    check("comb_in_reset", o_32_mul, 32'h4000_0000);
    @(posedge i_clk);
    #1;
`endif
    i_rst_n = 1'b1;

    // Basic products
    vec("one_x_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    vec("one_x_2p99",    32'h3F80_0000, 32'h403F_5C29, 32'h403F_5C29);
    vec("two_x_neg3",    32'h4000_0000, 32'hC040_0000, 32'hC0C0_0000);
    // Zeros and infinity*zero
    vec("pz_x_nz",       32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
    vec("pinf_x_pz",     32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    vec("ninf_x_pz",     32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000);
    vec("pz_x_ninf",     32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000);
    vec("nz_x_one",      32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    vec("sub_x_zero",    32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
    // Infinities
    vec("ninf_x_neg",    32'hFF80_0000, 32'hC00C_CCCD, 32'h7F80_0000);
    vec("pinf_x_neg",    32'h7F80_0000, 32'hC00C_CCCD, 32'hFF80_0000);
    vec("ninf_x_pinf",   32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000);
    // NaNs
    vec("pnan_x_neg",    32'h7F80_0001, 32'hC00C_CCCD, 32'h7FC0_0000);
    vec("nnan_x_pos",    32'hFF80_0001, 32'h4053_3333, 32'h7FC0_0000);
    vec("nan_x_zero",    32'h0000_0000, 32'hFFC0_0000, 32'h7FC0_0000);
    // Extreme operands
    vec("max_x_minn",    32'h7F7F_FFFF, 32'h00FF_FFFF, 32'h40FF_FFFE);
    vec("tiny_sq",       32'h00FF_FFFF, 32'h00FF_FFFF, 32'h0000_0000);
    vec("max_sq",        32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    vec("max_ovf_edge",  32'h7F7F_FFFF, 32'h3F80_0001, 32'h7F80_0000);
    // Rounding
    vec("rne_tie_up",    32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002);
    vec("rne_tie_even",  32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004);
    vec("rne_below_half",32'h3F80_0001, 32'h3FFF_FFFF, 32'h4000_0000);
    // Subnormals
    vec("sub_to_normal", 32'h0040_0000, 32'h4000_0000, 32'h0080_0000);
    vec("gradual_uf",    32'h0080_0000, 32'h3F00_0000, 32'h0040_0000);
    vec("sub_to_minnorm",32'h00FF_FFFF, 32'h3F00_0000, 32'h0080_0000);
    vec("minsub_tie_0",  32'h0000_0001, 32'h3F00_0000, 32'h0000_0000);
    vec("minsub_up",     32'h0000_0001, 32'h3F40_0000, 32'h0000_0001);
    vec("neg_minsub_up", 32'h8000_0001, 32'h3F40_0000, 32'h8000_0001);

`ifdef FPU_MUL_OUT_REG_EN
    // Latency: output holds the previous result until the next edge
    i_32_a = 32'h4000_0000;
    i_32_b = 32'h4040_0000;
    #1;
    check("latency_hold", o_32_mul, 32'h8000_0001);
    @(posedge i_clk);
    #1;
    check("latency_new", o_32_mul, 32'h40C0_0000);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_clear", o_32_mul, 32'h0000_0000);
    @(posedge i_clk);
    #1;
    check("clear_hold", o_32_mul, 32'h0000_0000);
    i_rst_n = 1'b1;
    vec("after_reset", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
`else
    // Zero latency and reset has no effect on the result
    i_32_a = 32'h4000_0000;
    i_32_b = 32'h4040_0000;
    #1;
    check("comb_latency", o_32_mul, 32'h40C0_0000);
    i_rst_n = 1'b0;
    #1;
    check("comb_reset_ignored", o_32_mul, 32'h40C0_0000);
    i_rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
